// File: rtl/ibex_bcp_csr.sv
// BCP CSR block: region address/config registers, global security config,
// and sticky first-fault capture of bound-check violations reported by EX.
module ibex_bcp_csr #(
    parameter int unsigned BCPNumRegions = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    output logic                          csr_hit_o,
    input  logic                          bcp_load_addr_err_i,
    input  logic                          bcp_store_addr_err_i,
    input  logic                          bcp_arith_addr_err_i,
    input  logic [31:0]                   bcp_err_addr_i,
    output logic [BCPNumRegions-1:0][31:0] csr_bcp_addr_o,
    output logic [BCPNumRegions-1:0][7:0]  csr_bcp_cfg_o,
    output logic [1:0]                    csr_bcp_mseccfg_o
);
    localparam int NR = int'(BCPNumRegions);
    localparam logic [1:0] A_TOR  = 2'b10;
    localparam logic [1:0] A_RSVD = 2'b11;

    logic [NR-1:0][7:0]  cfg_q, cfg_d;
    logic [NR-1:0][31:0] addr_q, addr_d;
    logic                rlb_q, rlb_d;
    logic                en_q, en_d;
    logic                err_v_q, err_v_d;
    logic [1:0]          err_cause_q, err_cause_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [31:0]         err_addr_q, err_addr_d;

    logic          is_cfg, is_addr, is_sec, is_err, is_erraddr;
    logic [NR-1:0] lock_cfg, lock_addr;
    logic [NR:0]   tor_lock;
    logic          any_lock, err_any, err_wr;
    logic [1:0]    err_cause_new;

    assign is_cfg     = (csr_addr_i[11:2] == 10'h1F4);
    assign is_addr    = (csr_addr_i[11:4] == 8'h7E);
    assign is_sec     = (csr_addr_i == 12'h7F0);
    assign is_err     = (csr_addr_i == 12'h7F1);
    assign is_erraddr = (csr_addr_i == 12'h7F2);

    // Reserved A encoding keeps the previous mode; bits [6:5] are hardwired to 0.
    function automatic logic [7:0] cfg_warl(input logic [7:0] old_b, input logic [7:0] new_b);
        logic [1:0] a;
        a = (new_b[4:3] == A_RSVD) ? old_b[4:3] : new_b[4:3];
        return {new_b[7], 2'b00, a, new_b[2:0]};
    endfunction

    // A locked TOR region also protects the address register below it.
    always_comb begin
        lock_cfg  = '0;
        lock_addr = '0;
        tor_lock  = '0;
        for (int i = 0; i < NR; i++) begin
            lock_cfg[i] = cfg_q[i][7] & ~rlb_q;
            tor_lock[i] = lock_cfg[i] & (cfg_q[i][4:3] == A_TOR);
        end
        for (int i = 0; i < NR; i++) begin
            lock_addr[i] = lock_cfg[i] | tor_lock[i+1];
        end
    end

    assign any_lock      = |lock_cfg;
    assign err_any       = bcp_load_addr_err_i | bcp_store_addr_err_i | bcp_arith_addr_err_i;
    assign err_wr        = csr_we_i & (is_err | is_erraddr);
    assign err_cause_new = bcp_load_addr_err_i  ? 2'b01 :
                           bcp_store_addr_err_i ? 2'b10 : 2'b11;

    always_comb begin
        cfg_d       = cfg_q;
        addr_d      = addr_q;
        rlb_d       = rlb_q;
        en_d        = en_q;
        err_v_d     = err_v_q;
        err_cause_d = err_cause_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;

        if (csr_we_i) begin
            for (int i = 0; i < NR; i++) begin
                if (is_cfg && (csr_addr_i[1:0] == i[3:2]) && !lock_cfg[i]) begin
                    cfg_d[i] = cfg_warl(cfg_q[i], csr_wdata_i[8*(i%4) +: 8]);
                end
                if (is_addr && (csr_addr_i[3:0] == i[3:0]) && !lock_addr[i]) begin
                    addr_d[i] = csr_wdata_i;
                end
            end
            if (is_sec) begin
                en_d = csr_wdata_i[1];
                if (!any_lock) begin
                    rlb_d = csr_wdata_i[0];
                end
            end
            if (is_err) begin
                err_v_d     = csr_wdata_i[31];
                err_cause_d = csr_wdata_i[17:16];
                err_cnt_d   = csr_wdata_i[7:0];
            end
            if (is_erraddr) begin
                err_addr_d = csr_wdata_i;
            end
        end

        // A software write to either error CSR discards a same-cycle violation.
        if (err_any && !err_wr) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (!err_v_q) begin
                err_v_d     = 1'b1;
                err_cause_d = err_cause_new;
                err_addr_d  = bcp_err_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q       <= '0;
            addr_q      <= '0;
            rlb_q       <= 1'b0;
            en_q        <= 1'b0;
            err_v_q     <= 1'b0;
            err_cause_q <= 2'b00;
            err_cnt_q   <= 8'h00;
            err_addr_q  <= 32'h0;
        end else begin
            cfg_q       <= cfg_d;
            addr_q      <= addr_d;
            rlb_q       <= rlb_d;
            en_q        <= en_d;
            err_v_q     <= err_v_d;
            err_cause_q <= err_cause_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_comb begin
        csr_rdata_o = 32'h0;
        csr_hit_o   = 1'b0;
        if (is_cfg) begin
            csr_hit_o = ({1'b0, csr_addr_i[1:0], 2'b00} < 5'(NR));
            for (int i = 0; i < NR; i++) begin
                if (csr_addr_i[1:0] == i[3:2]) begin
                    csr_rdata_o[8*(i%4) +: 8] = cfg_q[i];
                end
            end
        end else if (is_addr) begin
            csr_hit_o = ({1'b0, csr_addr_i[3:0]} < 5'(NR));
            for (int i = 0; i < NR; i++) begin
                if (csr_addr_i[3:0] == i[3:0]) begin
                    csr_rdata_o = addr_q[i];
                end
            end
        end else if (is_sec) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = {30'h0, en_q, rlb_q};
        end else if (is_err) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = {err_v_q, 13'h0, err_cause_q, 8'h00, err_cnt_q};
        end else if (is_erraddr) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = err_addr_q;
        end
    end

    assign csr_bcp_addr_o    = addr_q;
    assign csr_bcp_cfg_o     = cfg_q;
    assign csr_bcp_mseccfg_o = {en_q, rlb_q};

endmodule

// File: tb/tb_ibex_bcp_csr.sv
// Bench for ibex_bcp_csr: field-level reference model of the CSR rules,
// directed literal checks plus a randomized run with async resets.
module tb_ibex_bcp_csr;
    localparam int N = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              csr_we_i;
    logic [11:0]       csr_addr_i;
    logic [31:0]       csr_wdata_i;
    logic [31:0]       csr_rdata_o;
    logic              csr_hit_o;
    logic              ld_i, st_i, ar_i;
    logic [31:0]       eaddr_i;
    logic [N-1:0][31:0] bcp_addr;
    logic [N-1:0][7:0]  bcp_cfg;
    logic [1:0]        bcp_sec;

    ibex_bcp_csr #(.BCPNumRegions(N)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .csr_we_i             (csr_we_i),
        .csr_addr_i           (csr_addr_i),
        .csr_wdata_i          (csr_wdata_i),
        .csr_rdata_o          (csr_rdata_o),
        .csr_hit_o            (csr_hit_o),
        .bcp_load_addr_err_i  (ld_i),
        .bcp_store_addr_err_i (st_i),
        .bcp_arith_addr_err_i (ar_i),
        .bcp_err_addr_i       (eaddr_i),
        .csr_bcp_addr_o       (bcp_addr),
        .csr_bcp_cfg_o        (bcp_cfg),
        .csr_bcp_mseccfg_o    (bcp_sec)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: every region field held separately.
    bit          m_l[16], m_ar[16], m_st[16], m_ld[16];
    int          m_a[16];
    logic [31:0] m_addr[16];
    bit          m_rlb, m_en, m_v;
    int          m_cause, m_cnt;
    logic [31:0] m_eaddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_byte(input int r);
        return {m_l[r], 2'b00, 2'(m_a[r]), m_ar[r], m_st[r], m_ld[r]};
    endfunction

    function automatic logic [31:0] m_read(input int a, output bit hit);
        logic [31:0] d = 0;
        hit = 0;
        if (a >= 'h7D0 && a <= 'h7D3) begin
            hit = (4 * (a - 'h7D0)) < N;
            for (int k = 0; k < 4; k++)
                if (4 * (a - 'h7D0) + k < N) d |= 32'(m_byte(4 * (a - 'h7D0) + k)) << (8 * k);
        end else if (a >= 'h7E0 && a <= 'h7EF) begin
            hit = (a - 'h7E0) < N;
            if (hit) d = m_addr[a - 'h7E0];
        end else if (a == 'h7F0) begin
            hit = 1; d = {30'h0, m_en, m_rlb};
        end else if (a == 'h7F1) begin
            hit = 1; d = (32'(m_v) << 31) | (32'(m_cause) << 16) | 32'(m_cnt);
        end else if (a == 'h7F2) begin
            hit = 1; d = m_eaddr;
        end
        return d;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_l[r] = 0; m_ar[r] = 0; m_st[r] = 0; m_ld[r] = 0; m_a[r] = 0; m_addr[r] = 0;
        end
        m_rlb = 0; m_en = 0; m_v = 0; m_cause = 0; m_cnt = 0; m_eaddr = 0;
    endtask

    // Apply one clock edge worth of rules, using the pre-edge state throughout.
    task automatic model_step();
        bit lk[17], tor[17];
        bit any_l = 0;
        int a = int'(csr_addr_i);
        logic [31:0] w = csr_wdata_i;
        bit errw = csr_we_i && (a == 'h7F1 || a == 'h7F2);
        for (int r = 0; r < 17; r++) begin
            lk[r]  = (r < N) && m_l[r] && !m_rlb;
            tor[r] = lk[r] && (m_a[r] == 2);
            if (lk[r]) any_l = 1;
        end
        if (csr_we_i) begin
            if (a >= 'h7D0 && a <= 'h7D3) begin
                for (int k = 0; k < 4; k++) begin
                    int r = 4 * (a - 'h7D0) + k;
                    logic [7:0] b = w[8*k +: 8];
                    if (r < N && !lk[r]) begin
                        m_l[r] = b[7];
                        if (b[4:3] != 2'b11) m_a[r] = int'(b[4:3]);
                        m_ar[r] = b[2]; m_st[r] = b[1]; m_ld[r] = b[0];
                    end
                end
            end
            if (a >= 'h7E0 && a <= 'h7EF) begin
                int i = a - 'h7E0;
                if (i < N && !lk[i] && !tor[i+1]) m_addr[i] = w;
            end
            if (a == 'h7F0) begin
                m_en = w[1];
                if (!any_l) m_rlb = w[0];
            end
            if (a == 'h7F1) begin
                m_v = w[31]; m_cause = int'(w[17:16]); m_cnt = int'(w[7:0]);
            end
            if (a == 'h7F2) m_eaddr = w;
        end
        if ((ld_i || st_i || ar_i) && !errw) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_v) begin
                m_v = 1;
                m_cause = ld_i ? 1 : (st_i ? 2 : 3);
                m_eaddr = eaddr_i;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en && rst_ni) begin
            bit h;
            logic [31:0] d;
            d = m_read(int'(csr_addr_i), h);
            chk("rdata", csr_rdata_o, d);
            chk("hit", 32'(csr_hit_o), 32'(h));
            chk("mseccfg_o", 32'(bcp_sec), {30'h0, m_en, m_rlb});
            for (int i = 0; i < N; i++) begin
                chk($sformatf("addr_o[%0d]", i), bcp_addr[i], m_addr[i]);
                chk($sformatf("cfg_o[%0d]", i), 32'(bcp_cfg[i]), 32'(m_byte(i)));
            end
        end
    end

    task automatic step(input bit we, input logic [11:0] a, input logic [31:0] wd,
                        input bit ld, input bit st, input bit ar, input logic [31:0] ea);
        csr_we_i = we; csr_addr_i = a; csr_wdata_i = wd;
        ld_i = ld; st_i = st; ar_i = ar; eaddr_i = ea;
        @(posedge clk_i);
        model_step();
        #1;
        csr_we_i = 0; ld_i = 0; st_i = 0; ar_i = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd);
        step(1, a, wd, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        csr_we_i = 0; csr_addr_i = a;
        #1;
        chk(nm, csr_rdata_o, exp);
    endtask

    // Async reset between edges; optionally with an error pending that must be lost.
    task automatic do_reset(input bit pend_err);
        ld_i = pend_err; eaddr_i = 32'hDEAD_0000;
        #2;
        rst_ni = 0;
        model_reset();
        #1;
        chk("rst addr_o", 32'(|bcp_addr), 0);
        chk("rst cfg_o", 32'(|bcp_cfg), 0);
        chk("rst sec_o", 32'(bcp_sec), 0);
        chk("rst rdata", csr_rdata_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        ld_i = 0;
        #1 rst_ni = 1;
    endtask

    initial begin
        rst_ni = 0; csr_we_i = 0; csr_addr_i = 12'h7D0; csr_wdata_i = 0;
        ld_i = 0; st_i = 0; ar_i = 0; eaddr_i = 0;
        model_reset();
        #12 rst_ni = 1;
        chk_en = 1;

        rd(12'h7D0, 32'h0, "reset cfg0");
        rd(12'h7F1, 32'h0, "reset err");
        chk("reset sec_o", 32'(bcp_sec), 0);

        // WARL on reserved A
        wr(12'h7D0, 32'h0000_1F07);
        rd(12'h7D0, 32'h0000_0707, "cfg0 warl");

        // TOR lock on region 1 freezes ADDR0 and ADDR1
        wr(12'h7E0, 32'h1000);
        wr(12'h7E1, 32'h2000);
        wr(12'h7D0, 32'h0000_9007);
        rd(12'h7D0, 32'h0000_9007, "cfg0 lock");
        wr(12'h7E0, 32'h3000);
        wr(12'h7E1, 32'h4000);
        wr(12'h7E2, 32'h5000);
        rd(12'h7E0, 32'h1000, "addr0 tor frozen");
        rd(12'h7E1, 32'h2000, "addr1 locked");
        rd(12'h7E2, 32'h5000, "addr2 writable");
        wr(12'h7D0, 32'h0000_0000);
        rd(12'h7D0, 32'h0000_9000, "cfg0 partial lock");

        // RLB sticky off while locked
        wr(12'h7F0, 32'h1);
        rd(12'h7F0, 32'h0, "rlb sticky");
        wr(12'h7F0, 32'h3);
        rd(12'h7F0, 32'h2, "en set rlb off");

        do_reset(0);
        wr(12'h7F0, 32'h1);
        rd(12'h7F0, 32'h1, "rlb set");
        wr(12'h7D0, 32'h80);
        wr(12'h7E0, 32'h1234);
        rd(12'h7E0, 32'h1234, "rlb bypass");
        wr(12'h7F0, 32'h0);
        wr(12'h7E0, 32'h5678);
        rd(12'h7E0, 32'h1234, "lock after rlb off");

        // Error capture
        step(0, 12'h7F1, 0, 0, 1, 0, 32'h8000_0010);
        step(0, 12'h7F1, 0, 1, 0, 0, 32'h44);
        rd(12'h7F1, 32'h8002_0002, "err first fault");
        rd(12'h7F2, 32'h8000_0010, "erraddr first fault");
        step(1, 12'h7F1, 32'h0, 1, 0, 1, 32'h99);
        rd(12'h7F1, 32'h0, "err write wins");
        step(0, 12'h7F1, 0, 1, 0, 1, 32'h77);
        rd(12'h7F1, 32'h8001_0001, "err priority");
        for (int i = 0; i < 299; i++) step(0, 12'h7F1, 0, 0, 0, 1, 32'(i));
        rd(12'h7F1, 32'h8001_00FF, "err cnt saturate");
        rd(12'h7F2, 32'h77, "erraddr sticky");

        rd(12'h7E5, 32'h0, "unimpl addr");
        chk("unimpl addr hit", 32'(csr_hit_o), 0);
        rd(12'h7D1, 32'h0, "unimpl cfg1");
        chk("unimpl cfg1 hit", 32'(csr_hit_o), 0);

        csr_addr_i = 12'h7F1;
        do_reset(1);
        #1;
        chk("pending err dropped", csr_rdata_o, 0);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            int sel;
            logic [11:0] a;
            logic [31:0] wd;
            sel = $urandom_range(0, 9);
            if (sel <= 2)      a = 12'h7D0 + 12'($urandom_range(0, 3));
            else if (sel <= 5) a = 12'h7E0 + 12'($urandom_range(0, 15));
            else if (sel == 6) a = 12'h7F0;
            else if (sel == 7) a = 12'h7F1;
            else if (sel == 8) a = 12'h7F2;
            else               a = 12'($urandom);
            wd = $urandom;
            if (sel <= 2 && $urandom_range(0, 3) != 0) wd &= 32'h7F7F_7F7F;
            step($urandom_range(0, 2) == 0, a, wd,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom);
            if (c % 700 == 699) do_reset($urandom_range(0, 1) == 1);
        end

        @(negedge clk_i);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
